// File: rtl/vliw_pkg.sv
// +----------------------------------------------------------------------------+
// | vliw_pkg: shared register-file geometry, slot latencies and decode opcodes |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vliw_pkg;

  localparam int REG_IDX_W   = 3;
  localparam int NUM_REGS    = 8;
  localparam int ALU_LAT_DEF = 2;
  localparam int MEM_LAT_DEF = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [4:0] {
    OP_NOOP   = 5'b00000,
    OP_STOREB = 5'b01100,
    OP_LOADB  = 5'b01101,
    OP_BRANCH = 5'b11010,
    OP_JUMP   = 5'b11110
  } slot_op_e;

  function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
// +----------------------------------------------------------------------------+
// | sb_counter: per-register countdown until a write is readable               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  logic [CNT_W-1:0] count_d, count_q;

  // A new write replaces whatever is left of the older countdown.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign pending = |count_q;

endmodule

`default_nettype wire

// File: rtl/vliw_issue_scoreboard.sv
// +----------------------------------------------------------------------------+
// | vliw_issue_scoreboard: ID-stage RAW/WAW stall for the ALU+MEM VLIW bundle  |
// | Optional macro SB_STATS_EN adds stall_cycles / conflict_count. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vliw_issue_scoreboard
  import vliw_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic                 alu_useRm,
  input  logic                 alu_regWrite,
  input  logic [REG_IDX_W-1:0] alu_rm,
  input  logic [REG_IDX_W-1:0] alu_rn,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic                 mem_valid,
  input  logic                 mem_isLoad,
  input  logic                 mem_isStore,
  input  logic [REG_IDX_W-1:0] mem_rn,
  input  logic [REG_IDX_W-1:0] mem_rd,
  output logic                 stall,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  pending,
`ifdef SB_STATS_EN
  output logic [15:0]          stall_cycles,
  output logic [7:0]           conflict_count,
`endif
  output logic                 wb_conflict
);

  localparam logic [CNT_W-1:0] ALU_LAT_C  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] MEM_LAT_C  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] BOTH_LAT_C = CNT_W'(lat_max(ALU_LAT, MEM_LAT));

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ld_en;
  logic [CNT_W-1:0]    ld_val [NUM_REGS];
  logic                alu_wr, mem_ld, same_rd;
  logic                raw, waw, bundle_live;
  logic                wb_conflict_d, wb_conflict_q;

  assign alu_wr      = alu_valid & alu_regWrite;
  assign mem_ld      = mem_valid & mem_isLoad;
  assign same_rd     = alu_wr & mem_ld & (alu_rd == mem_rd);
  assign bundle_live = ~reset & id_valid & ~flush;

  // WAW blocks a write whose countdown would finish before an older one.
  always_comb begin
    raw = 1'b0;
    if (alu_valid && cnt[alu_rn] != '0)                 raw = 1'b1;
    if (alu_valid && alu_useRm && cnt[alu_rm] != '0)    raw = 1'b1;
    if (mem_valid && cnt[mem_rn] != '0)                 raw = 1'b1;
    if (mem_valid && mem_isStore && cnt[mem_rd] != '0)  raw = 1'b1;
    waw = 1'b0;
    if (alu_wr && cnt[alu_rd] > ALU_LAT_C)              waw = 1'b1;
    if (mem_ld && cnt[mem_rd] > MEM_LAT_C)              waw = 1'b1;
  end

  assign stall = bundle_live & (raw | waw);
  assign issue = bundle_live & ~(raw | waw);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic alu_hit, mem_hit;

      assign alu_hit  = alu_wr & (alu_rd == REG_IDX_W'(i));
      assign mem_hit  = mem_ld & (mem_rd == REG_IDX_W'(i));
      assign ld_en[i] = issue & (alu_hit | mem_hit);
      assign ld_val[i] = (alu_hit & mem_hit) ? BOTH_LAT_C :
                         alu_hit             ? ALU_LAT_C  : MEM_LAT_C;

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ld_en[i]),
        .load_val (ld_val[i]),
        .count    (cnt[i]),
        .pending  (pending[i])
      );
    end
  endgenerate

  always_comb begin
    wb_conflict_d = issue & same_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_conflict_q <= 1'b0;
    end else begin
      wb_conflict_q <= wb_conflict_d;
    end
  end

  assign wb_conflict = wb_conflict_q;

`ifdef SB_STATS_EN
  logic [15:0] stall_cycles_d, stall_cycles_q;
  logic [7:0]  conflict_count_d, conflict_count_q;

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    conflict_count_d = conflict_count_q;
    if (stall && stall_cycles_q != 16'hFFFF)          stall_cycles_d   = stall_cycles_q + 16'd1;
    if (wb_conflict_q && conflict_count_q != 8'hFF)   conflict_count_d = conflict_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q   <= '0;
      conflict_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign conflict_count = conflict_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vliw_issue_scoreboard.sv
// +----------------------------------------------------------------------------+
// | tb_vliw_issue_scoreboard: directed scenarios plus randomized model check   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vliw_issue_scoreboard;

  localparam int ALU_LAT = 2;
  localparam int MEM_LAT = 3;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, flush;
  logic       alu_valid, alu_useRm, alu_regWrite;
  logic [2:0] alu_rm, alu_rn, alu_rd;
  logic       mem_valid, mem_isLoad, mem_isStore;
  logic [2:0] mem_rn, mem_rd;
  logic       stall, issue, wb_conflict;
  logic [7:0] pending;
`ifdef SB_STATS_EN
  logic [15:0] stall_cycles;
  logic [7:0]  conflict_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: cycles remaining until each register is readable.
  int   mcnt [8];
  logic exp_wbc;
  int   m_stall_cycles, m_conflicts;

  always #5 clk = ~clk;

  vliw_issue_scoreboard #(
    .ALU_LAT (ALU_LAT),
    .MEM_LAT (MEM_LAT),
    .CNT_W   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .flush          (flush),
    .alu_valid      (alu_valid),
    .alu_useRm      (alu_useRm),
    .alu_regWrite   (alu_regWrite),
    .alu_rm         (alu_rm),
    .alu_rn         (alu_rn),
    .alu_rd         (alu_rd),
    .mem_valid      (mem_valid),
    .mem_isLoad     (mem_isLoad),
    .mem_isStore    (mem_isStore),
    .mem_rn         (mem_rn),
    .mem_rd         (mem_rd),
    .stall          (stall),
    .issue          (issue),
    .pending        (pending),
`ifdef SB_STATS_EN
    .stall_cycles   (stall_cycles),
    .conflict_count (conflict_count),
`endif
    .wb_conflict    (wb_conflict)
  );

  task automatic drive(input logic v, input logic fl,
                       input logic av, input logic au, input logic aw,
                       input logic [2:0] arm, input logic [2:0] arn, input logic [2:0] ard,
                       input logic mv, input logic ml, input logic ms,
                       input logic [2:0] mrn, input logic [2:0] mrd);
    id_valid = v;   flush = fl;
    alu_valid = av; alu_useRm = au; alu_regWrite = aw;
    alu_rm = arm;   alu_rn = arn;   alu_rd = ard;
    mem_valid = mv; mem_isLoad = ml; mem_isStore = ms;
    mem_rn = mrn;   mem_rd = mrd;
  endtask

  task automatic drive_idle();
    drive(T, F, F, F, F, 3'd0, 3'd0, 3'd0, F, F, F, 3'd0, 3'd0);
  endtask

  function automatic logic m_stall();
    logic raw, waw;
    if (reset || !id_valid || flush) return 1'b0;
    raw = (alu_valid && mcnt[alu_rn] != 0) ||
          (alu_valid && alu_useRm && mcnt[alu_rm] != 0) ||
          (mem_valid && mcnt[mem_rn] != 0) ||
          (mem_valid && mem_isStore && mcnt[mem_rd] != 0);
    waw = (alu_valid && alu_regWrite && mcnt[alu_rd] > ALU_LAT) ||
          (mem_valid && mem_isLoad && mcnt[mem_rd] > MEM_LAT);
    return raw || waw;
  endfunction

  function automatic logic m_issue();
    return !reset && id_valid && !flush && !m_stall();
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int r = 0; r < 8; r++) p[r] = (mcnt[r] != 0);
    return p;
  endfunction

  // Advance the model across one rising edge using the inputs held over it.
  task automatic tick();
    logic iss, stl, conf;
    iss  = m_issue();
    stl  = m_stall();
    conf = iss && alu_valid && alu_regWrite && mem_valid && mem_isLoad && (alu_rd == mem_rd);
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 8; r++) mcnt[r] = 0;
      exp_wbc = 1'b0;
      m_stall_cycles = 0;
      m_conflicts = 0;
    end else begin
      if (exp_wbc && m_conflicts < 255) m_conflicts++;
      if (stl && m_stall_cycles < 65535) m_stall_cycles++;
      for (int r = 0; r < 8; r++) if (mcnt[r] > 0) mcnt[r]--;
      if (iss) begin
        if (alu_valid && alu_regWrite) mcnt[alu_rd] = ALU_LAT;
        if (mem_valid && mem_isLoad)   mcnt[mem_rd] = MEM_LAT;
        if (conf) mcnt[mem_rd] = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
      end
      exp_wbc = conf;
    end
  endtask

  task automatic quiesce();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_idle();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({stall, issue, wb_conflict, pending} !== 11'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, {stall, issue, wb_conflict, pending}, 11'b0);
      end
      tick();
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    vectors++;
    if ({stall, issue, wb_conflict, pending} !== {3'b010, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", {stall, issue, wb_conflict, pending}, {3'b010, 8'h00});
    end
    tick();
  endtask

  task automatic test_raw();
    logic [2:0] want [4];
    want = '{3'b010, 3'b101, 3'b101, 3'b010};
    quiesce();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(T, F, T, F, T, 3'd0, 3'd0, 3'd3, F, F, F, 3'd0, 3'd0);
      else        drive(T, F, T, F, F, 3'd0, 3'd3, 3'd0, F, F, F, 3'd0, 3'd0);
      #1;
      vectors++;
      if ({stall, issue, pending[3]} !== want[i] && i > 0) begin
        miscompares++;
        $display("FAIL raw_step%0d: got %b want %b", i, {stall, issue, pending[3]}, want[i]);
      end else if (i == 0 && {stall, issue} !== 2'b01) begin
        miscompares++;
        $display("FAIL raw_producer: got %b want 01", {stall, issue});
      end
      tick();
    end
  endtask

  task automatic test_waw();
    logic [2:0] want [6];
    want = '{3'b010, 3'b101, 3'b011, 3'b011, 3'b011, 3'b010};
    quiesce();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0)      drive(T, F, F, F, F, 3'd0, 3'd0, 3'd0, T, T, F, 3'd0, 3'd5);
      else if (i <= 2) drive(T, F, T, F, T, 3'd0, 3'd0, 3'd5, F, F, F, 3'd0, 3'd0);
      else             drive_idle();
      #1;
      vectors++;
      if ({stall, issue, pending[5]} !== want[i]) begin
        miscompares++;
        $display("FAIL waw_step%0d: got %b want %b", i, {stall, issue, pending[5]}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    logic [3:0] want [5];
    // {issue, wb_conflict, pending[2], stall}
    want = '{4'b1000, 4'b1110, 4'b1010, 4'b1010, 4'b1000};
    quiesce();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) drive(T, F, T, F, T, 3'd0, 3'd0, 3'd2, T, T, F, 3'd0, 3'd2);
      else        drive_idle();
      #1;
      vectors++;
      if ({issue, wb_conflict, pending[2], stall} !== want[i]) begin
        miscompares++;
        $display("FAIL conflict_step%0d: got %b want %b", i, {issue, wb_conflict, pending[2], stall}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [3:0] want [5];
    // {stall, issue, pending[1], pending[6]}
    want = '{4'b0100, 4'b0010, 4'b0010, 4'b0110, 4'b0100};
    quiesce();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0:       drive(T, F, F, F, F, 3'd0, 3'd0, 3'd0, T, T, F, 3'd0, 3'd1);
        1:       drive(T, T, F, F, F, 3'd0, 3'd0, 3'd0, T, F, T, 3'd0, 3'd1);
        2:       drive(T, T, F, F, F, 3'd0, 3'd0, 3'd0, T, T, F, 3'd0, 3'd6);
        default: drive_idle();
      endcase
      #1;
      vectors++;
      if ({stall, issue, pending[1], pending[6]} !== want[i]) begin
        miscompares++;
        $display("FAIL flush_step%0d: got %b want %b", i, {stall, issue, pending[1], pending[6]}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    @(negedge clk);
    drive(T, F, F, F, F, 3'd0, 3'd0, 3'd0, T, T, F, 3'd0, 3'd4);
    tick();
    @(negedge clk);
    reset = 1'b1;
    drive(T, F, T, F, F, 3'd0, 3'd4, 3'd0, F, F, F, 3'd0, 3'd0);
    #1;
    vectors++;
    if ({stall, issue, pending[4]} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_mid_assert: got %b want 001", {stall, issue, pending[4]});
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({stall, issue, pending} !== {2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid_release: got %b want %b", {stall, issue, pending}, {2'b01, 8'h00});
    end
`ifdef SB_STATS_EN
    vectors++;
    if (stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_stats: got %0d want 0", stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    logic held;
    held = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 1);
      if (!(held && $urandom_range(0, 99) < 80)) begin
        drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 60,
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        if (mem_isLoad && mem_isStore) mem_isStore = 1'b0;
        if ($urandom_range(0, 99) < 15) begin
          alu_rd = mem_rd;
          alu_valid = 1'b1; alu_regWrite = 1'b1;
          mem_valid = 1'b1; mem_isLoad = 1'b1; mem_isStore = 1'b0;
        end
      end
      #1;
      vectors++;
      if ({stall, issue, wb_conflict, pending} !== {m_stall(), m_issue(), exp_wbc, m_pend()}) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %b want %b", i,
                 {stall, issue, wb_conflict, pending}, {m_stall(), m_issue(), exp_wbc, m_pend()});
      end
`ifdef SB_STATS_EN
      vectors++;
      if (stall_cycles !== 16'(m_stall_cycles) || conflict_count !== 8'(m_conflicts)) begin
        miscompares++;
        $display("FAIL random_stats%0d: got %0d/%0d want %0d/%0d", i,
                 stall_cycles, conflict_count, m_stall_cycles, m_conflicts);
      end
`endif
      held = m_stall();
      tick();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    exp_wbc = 1'b0;
    m_stall_cycles = 0;
    m_conflicts = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_raw();
    test_waw();
    test_conflict();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
